// File: rtl/udp_sched_pkg.sv
// rtl/udp_sched_pkg.sv - state encoding and default timing constants for the UDP TX scheduler
package udp_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } sched_state_e;

  localparam int GAP_CYCLES_DEFAULT     = 96;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1_000_000;

  // A zero-length gap still needs one cycle to deliver the result pulses.
  function automatic int at_least_one(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the previous owner
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_i,
  output logic [$clog2(NUM_REQ)-1:0] winner_o,
  output logic                       any_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate down to last+1 so the nearest requester overwrites.
  always_comb begin
    winner_o = '0;
    cand     = '0;
    any_o    = |req_i;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(last_i) + k) % NUM_REQ);
      if (req_i[cand]) begin
        winner_o = cand;
      end
    end
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// rtl/udp_tx_scheduler.sv - shares one UDP transmitter between NUM_REQ producers with gap and watchdog
module udp_tx_scheduler
  import udp_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       tx_ready_i,
  output logic                       tx_send_o,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] sel_o,
  output logic                       busy_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       timeout_o,
  output logic [COUNT_WIDTH-1:0]     pkt_count_o
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int GAP_LEN = at_least_one(GAP_CYCLES);
  localparam int GW      = $clog2(GAP_LEN + 1);
  localparam int WW      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GW-1:0]      GAP_LAST  = GW'(GAP_LEN - 1);
  localparam logic [WW-1:0]      WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  sched_state_e           state_q, state_d;
  logic [IW-1:0]          sel_q, sel_d;
  logic [IW-1:0]          last_q, last_d;
  logic [WW-1:0]          wdog_q, wdog_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   tx_send_q, tx_send_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   timeout_q, timeout_d;

  logic [IW-1:0] arb_winner;
  logic          arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i    (req_i),
    .last_i   (last_q),
    .winner_o (arb_winner),
    .any_o    (arb_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      last_q    <= IW'(NUM_REQ - 1);
      wdog_q    <= '0;
      gap_q     <= '0;
      cnt_q     <= '0;
      tx_send_q <= 1'b0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      tx_send_q <= tx_send_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs are computed alongside the next state so every one of them leaves a flop.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    tx_send_d = 1'b0;
    grant_d   = '0;
    done_d    = '0;
    timeout_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable_i && arb_any && tx_ready_i) begin
          state_d   = S_LAUNCH;
          sel_d     = arb_winner;
          tx_send_d = 1'b1;
          grant_d   = ONE_HOT0 << arb_winner;
        end
      end

      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT_ACK;
      end

      S_WAIT_ACK, S_WAIT_DONE: begin
        // Completion is tested first so a ready edge on the expiry cycle still counts.
        if (state_q == S_WAIT_DONE && tx_ready_i) begin
          state_d = S_GAP;
          gap_d   = '0;
          last_d  = sel_q;
          done_d  = ONE_HOT0 << sel_q;
          cnt_d   = cnt_q + COUNT_WIDTH'(1);
        end else if (wdog_q == WDOG_LAST) begin
          state_d   = S_GAP;
          gap_d     = '0;
          last_d    = sel_q;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WW'(1);
          if (state_q == S_WAIT_ACK && !tx_ready_i) begin
            state_d = S_WAIT_DONE;
          end
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign tx_send_o   = tx_send_q;
  assign grant_o     = grant_q;
  assign sel_o       = sel_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign pkt_count_o = cnt_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb/tb_udp_tx_scheduler.sv - scoreboard bench for udp_tx_scheduler with a transmitter model
module tb_udp_tx_scheduler;

  localparam int N   = 4;
  localparam int GAP = 96;
  localparam int TMO = 100;
  localparam int CW  = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          enable_i;
  logic [N-1:0]  req_i;
  logic          tx_ready_i;
  logic          tx_send_o;
  logic [N-1:0]  grant_o;
  logic [1:0]    sel_o;
  logic          busy_o;
  logic [N-1:0]  done_o;
  logic          timeout_o;
  logic [CW-1:0] pkt_count_o;

  always #5 clk_i = ~clk_i;

  udp_tx_scheduler #(
    .NUM_REQ        (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .COUNT_WIDTH    (CW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .enable_i    (enable_i),
    .req_i       (req_i),
    .tx_ready_i  (tx_ready_i),
    .tx_send_o   (tx_send_o),
    .grant_o     (grant_o),
    .sel_o       (sel_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o),
    .pkt_count_o (pkt_count_o)
  );

  typedef struct {
    int winner;
    bit is_done;
    int lat;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   td[$];
  int   th[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void note(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  // Transmitter: ready drops d cycles after send, rises h cycles later; d==0 never drops.
  int tx_phase = 0, tx_cnt = 0, tx_h = 0, epoch = 0, seen_epoch = 0, pd, ph;
  initial begin
    tx_ready_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        tx_phase   = 0;
        tx_ready_i = 1'b1;
      end else begin
        case (tx_phase)
          0: if (rst_ni && tx_send_o && td.size() > 0) begin
            pd = td.pop_front();
            ph = th.pop_front();
            if (pd > 0) begin
              tx_cnt   = pd;
              tx_h     = ph;
              tx_phase = 1;
            end
          end
          1: begin
            tx_cnt--;
            if (tx_cnt == 0) begin
              tx_ready_i = 1'b0;
              tx_cnt     = tx_h;
              tx_phase   = 2;
            end
          end
          default: begin
            tx_cnt--;
            if (tx_cnt == 0) begin
              tx_ready_i = 1'b1;
              tx_phase   = 0;
            end
          end
        endcase
      end
    end
  end

  // Monitor
  int   send_cyc = 0, res_cyc = -1000, n_send = 0, n_res = 0;
  logic [1:0] cur_sel = '0;
  bit   in_pkt = 0, sel_ok = 1;
  exp_t e;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      in_pkt  = 0;
      res_cyc = -1000;
    end else begin
      if (tx_send_o) begin
        n_send++;
        note(sb.size() > 0, "send_expected", sb.size(), 1);
        if (sb.size() > 0)
          note(grant_o == onehot(sb[0].winner), "grant", int'(grant_o), int'(onehot(sb[0].winner)));
        note((cyc - res_cyc) >= GAP + 1, "gap_before_send", cyc - res_cyc, GAP + 1);
        send_cyc = cyc;
        cur_sel  = sel_o;
        in_pkt   = 1;
        sel_ok   = 1;
      end else if (in_pkt && sel_o != cur_sel) begin
        sel_ok = 0;
      end
      if (done_o != '0 || timeout_o) begin
        n_res++;
        note(sb.size() > 0, "result_expected", sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          note(timeout_o == !e.is_done, "timeout_flag", int'(timeout_o), int'(!e.is_done));
          note(done_o == (e.is_done ? onehot(e.winner) : '0), "done_vec", int'(done_o),
               e.is_done ? int'(onehot(e.winner)) : 0);
          note((cyc - send_cyc) == e.lat, "result_latency", cyc - send_cyc, e.lat);
          note(int'(pkt_count_o) == e.cnt, "pkt_count", int'(pkt_count_o), e.cnt);
          note(sel_ok, "sel_stable", int'(sel_ok), 1);
          note(busy_o, "busy_in_gap", int'(busy_o), 1);
        end
        in_pkt  = 0;
        res_cyc = cyc;
      end
    end
  end

  // Reference model: plain round-robin over the request snapshot
  int m_last = N - 1, m_cnt = 0, set_cyc = 0;

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(m_last + k) % N]) return (m_last + k) % N;
    end
    return 0;
  endfunction

  function automatic int all_outs();
    return int'({tx_send_o, grant_o, sel_o, busy_o, done_o, timeout_o, pkt_count_o});
  endfunction

  // mode 0: normal, 1: drop enable in WAIT_DONE, 2: reset in WAIT_DONE
  task automatic send_pkt(input logic [N-1:0] r, input int d, input int h, input int mode);
    exp_t x;
    int   base;
    x.winner  = pick(r);
    x.is_done = (d > 0) && (d + h <= TMO);
    x.lat     = x.is_done ? d + h + 1 : TMO + 1;
    if (x.is_done) m_cnt = (m_cnt + 1) % (1 << CW);
    x.cnt  = m_cnt;
    m_last = x.winner;
    sb.push_back(x);
    td.push_back(d);
    th.push_back(h);
    base     = n_res;
    req_i    = r;
    enable_i = 1'b1;
    set_cyc  = cyc;
    if (mode != 0) begin
      for (int i = 0; i < 300 && !(busy_o && !tx_ready_i); i++) @(negedge clk_i);
      @(negedge clk_i);
      @(negedge clk_i);
      if (mode == 1) begin
        enable_i = 1'b0;
      end else begin
        #2 rst_ni = 1'b0;
        #1 note(all_outs() == 0, "async_reset_outputs", all_outs(), 0);
        sb.delete();
        td.delete();
        th.delete();
        m_last = N - 1;
        m_cnt  = 0;
        epoch++;
        req_i = '0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        return;
      end
    end
    for (int i = 0; i < 400 && n_res == base; i++) @(negedge clk_i);
    note(n_res != base, "result_seen", n_res - base, 1);
  endtask

  int n0;
  initial begin
    rst_ni   = 1'b0;
    enable_i = 1'b0;
    req_i    = '0;
    repeat (2) @(negedge clk_i);
    note(all_outs() == 0, "reset_outputs", all_outs(), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    send_pkt(4'b0010, 3, 50, 0);
    note(send_cyc - set_cyc == 1, "grant_latency", send_cyc - set_cyc, 1);

    for (int k = 0; k < 5; k++) send_pkt(4'b1111, $urandom_range(6, 1), $urandom_range(40, 5), 0);

    send_pkt(4'b1111, 0, 0, 0);
    send_pkt(4'b1111, 4, 96, 0);
    send_pkt(4'b1111, 4, 97, 0);

    for (int k = 0; k < 12; k++)
      send_pkt(4'($urandom_range(15, 1)), $urandom_range(8, 1), $urandom_range(110, 1), 0);

    enable_i = 1'b0;
    req_i    = 4'b0101;
    n0       = n_send;
    repeat (1000) @(negedge clk_i);
    note(n_send == n0, "no_send_while_disabled", n_send - n0, 0);
    note(busy_o == 1'b0, "idle_while_disabled", int'(busy_o), 0);
    send_pkt(4'b0101, 2, 20, 0);

    send_pkt(4'b1110, 3, 40, 1);
    n0 = n_send;
    repeat (200) @(negedge clk_i);
    note(n_send == n0, "no_send_after_enable_drop", n_send - n0, 0);

    send_pkt(4'b1111, 3, 60, 2);
    @(negedge clk_i);
    send_pkt(4'b1001, 2, 10, 0);
    note(send_cyc - set_cyc == 1, "grant_latency_after_reset", send_cyc - set_cyc, 1);

    for (int k = 0; k < 6; k++)
      send_pkt(4'($urandom_range(15, 1)), $urandom_range(8, 1), $urandom_range(60, 1), 0);
    req_i = '0;
    repeat (300) @(negedge clk_i);
    note(sb.size() == 0, "scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 60000);
    $fatal(1);
  end

endmodule

// File: doc/udp_tx_scheduler.md
# udp_tx_scheduler

Round-robin scheduler that shares one `ethernet_udp_transmit` instance between `NUM_REQ` payload producers. It picks a requester, drives the transmitter's one-cycle `send` strobe and the select index for the upstream data/`IPInfo` mux, and tracks completion through the transmitter's `ready` level. It enforces a minimum inter-packet gap and a watchdog timeout. It sits in the 100 MHz `clk` domain between the producers and the transmitter.

## Interface
- `NUM_REQ`, 4: number of requesters, at least 2.
- `GAP_CYCLES`, 96: idle `clk` cycles after each packet. The GAP state always lasts max(`GAP_CYCLES`, 1) cycles.
- `TIMEOUT_CYCLES`, 1_000_000: cycles allowed from launch to completion.
- `COUNT_WIDTH`, 16: width of `pkt_count`.
- `clk`  in  1  100 MHz system clock; the block has one clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new launches; does not affect a packet already in flight.
- `req`  in  `NUM_REQ`  level request; the producer holds it until it sees `grant`.
- `tx_ready`  in  1  `ready` from `ethernet_udp_transmit`.
- `tx_send`  out  1  one-cycle `send` pulse to the transmitter.
- `grant`  out  `NUM_REQ`  one-hot, one-cycle pulse, coincident with `tx_send`.
- `sel`  out  $clog2(`NUM_REQ`)  index of the current owner; stable from LAUNCH through GAP.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  `NUM_REQ`  one-hot, one-cycle pulse on successful completion.
- `timeout`  out  1  one-cycle pulse when the watchdog expires.
- `pkt_count`  out  `COUNT_WIDTH`  count of completed packets; wraps modulo 2^`COUNT_WIDTH`.

## Operation
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, GAP.
- **IDLE**
  - Condition to leave: `enable` && |`req` && `tx_ready`.
  - On that condition: register the winner into `sel` and go to LAUNCH.
- **Arbitration**
  - Priority order is `last`+1, `last`+2, … modulo `NUM_REQ`.
  - `last` resets to `NUM_REQ`-1, so `req[0]` has first priority after reset.
- **LAUNCH** (one cycle)
  - `tx_send`=1 and `grant[sel]`=1.
  - Clear the watchdog counter and go to WAIT_ACK.
- **WAIT_ACK**
  - Wait for `tx_ready`=0 (the transmitter has accepted; its clock crossing takes several cycles), then go to WAIT_DONE.
- **WAIT_DONE**
  - Wait for `tx_ready`=1, then go to GAP with success.
- **Watchdog**
  - Increments each cycle spent in WAIT_ACK or WAIT_DONE.
  - When it reaches `TIMEOUT_CYCLES` without completion, go to GAP with failure.
  - If `tx_ready` rises in the same cycle as expiry, completion wins.
- **GAP**
  - The first GAP cycle carries the result:
    - success: `done[sel]`=1 and `pkt_count`+1;
    - failure: `timeout`=1 and `pkt_count` unchanged.
  - `last` <= `sel` in both cases.
  - After the gap, return to IDLE.
- Requests:
  - `req` changes after `grant` are ignored.
  - A requester dropping `req` before it is granted loses its turn without any side effect.
- `enable` deasserted: the in-flight packet runs to GAP and IDLE; no new launch occurs.
- Reset: asynchronous and takes effect immediately in any state.
  - State returns to IDLE.
  - All outputs go to 0: `tx_send`, `grant`, `sel`, `busy`, `done`, `timeout`, `pkt_count`.
  - `last` returns to `NUM_REQ`-1.
  - The watchdog counter and gap counter are cleared.

## Timing
- All outputs are registered (Moore).
- `req` seen in IDLE at cycle 0 → `tx_send`/`grant` high in cycle 1 (latency of 1).
- `tx_ready` seen high in WAIT_DONE at cycle k → `done` high in cycle k+1.
- The next possible `tx_send` is at cycle k+1+max(`GAP_CYCLES`, 1)+1.
- `tx_ready` is assumed already synchronised to `clk` by the transmitter; the block adds no synchronisers.
- Counters are sized from their parameters using $clog2; widths are not fixed at 32 bits.

## Structure
- Package `udp_sched_pkg`: the state enum typedef and the default constants `GAP_CYCLES_DEFAULT` = 96 and `TIMEOUT_CYCLES_DEFAULT` = 1_000_000.
- Sub-module `rr_arbiter`: purely combinational.
  - Inputs: `req` and `last`.
  - Outputs: `winner` index and `any`.
  - Reusable by other shared-resource blocks.
- The FSM, watchdog counter, gap counter and `pkt_count` live in `udp_tx_scheduler`.

## Test plan
- **Single packet:** `req[1]` only; the model drops `tx_ready` 3 cycles after `tx_send` and raises it 50 cycles later.
  - Expect `grant`=4'b0010 one cycle after the request.
  - Expect `done`=4'b0010 and `pkt_count`=1.
  - Expect the next `tx_send` no earlier than 97 cycles after `done`.
- **Fairness:** all four `req` held high.
  - Expect grant order 0, 1, 2, 3, 0.
  - Expect `sel` constant throughout each packet.
- **Timeout:** `TIMEOUT_CYCLES`=100 and `tx_ready` never drops.
  - Expect `timeout` pulse 101 cycles after `tx_send`, no `done`, and `pkt_count` unchanged.
  - Expect the next requester to be served after the gap.
- **Expiry vs completion:** `tx_ready` rises exactly on the expiry cycle.
  - Expect `done`, not `timeout`.
- **Reset mid-operation:** assert `reset` low in WAIT_DONE.
  - Expect all outputs 0 without waiting for a clock edge.
  - After release, with `req`=4'b1001, expect `grant[0]` first.
- **Enable and wrap:**
  - `enable` low with `req` pending → no `tx_send` for 1000 cycles.
  - `enable` dropped during WAIT_DONE → the packet still completes.
  - With `COUNT_WIDTH`=2, `pkt_count` reads 0 after 4 packets.
